// File: rtl/fifo_frame_reader_pkg.sv
// fifo_frame_reader_pkg: shared state encoding, pixel tag layout and counter width for the frame reader.
package fifo_frame_reader_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } tag_t;
  localparam int TAG_W = $bits(tag_t);
  localparam int CMP_W = 12;
endpackage

// File: rtl/fifo_frame_reader_skid.sv
// fifo_frame_reader_skid: 2-entry ready/valid buffer; in_ready is registered so upstream never sees out_ready.
module fifo_frame_reader_skid #(
  parameter int W = 19
) (
  input  logic         rd_clk,
  input  logic         rd_rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         push;
  assign in_ready = ~skid_valid;
  assign push     = in_valid & ~skid_valid;
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (~out_valid | out_ready) begin
      out_valid  <= skid_valid | push;
      out_data   <= skid_valid ? skid_data : (push ? in_data : out_data);
      skid_valid <= 1'b0;
    end else if (push) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data;
    end
endmodule

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pops a FWFT FIFO and frames H_ACTIVE x V_ACTIVE pixels with sof/eol/eof tags.
// Define FIFO_FRAME_READER_STALL_CNT_EN to add the upstream-starvation counter output stall_cnt.
module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int CNT_W    = CMP_W
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              frame_start,
  input  logic              abort,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_rd_vld,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy,
  output logic              done
`ifdef FIFO_FRAME_READER_STALL_CNT_EN
  ,output logic [31:0]      stall_cnt
`endif
);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);
  state_t                   state, state_d;
  logic [CNT_W-1:0]         x_cnt, y_cnt;
  logic                     in_ready, pop, x_last, y_last;
  tag_t                     tag;
  logic [TAG_W+DATA_W-1:0]  out_word;
  assign fifo_rd_en = (state == ACTIVE) & in_ready & ~abort;
  assign pop        = fifo_rd_en & fifo_rd_vld;
  assign x_last     = x_cnt == X_LAST;
  assign y_last     = y_cnt == Y_LAST;
  assign tag        = '{sof: (x_cnt == '0) & (y_cnt == '0), eol: x_last, eof: x_last & y_last};
  assign busy       = state != IDLE;
  assign {out_sof, out_eol, out_eof, out_data} = out_word;
  fifo_frame_reader_skid #(.W(TAG_W + DATA_W)) u_skid (
    .rd_clk    (rd_clk),
    .rd_rst    (rd_rst),
    .flush     (abort),
    .in_valid  (pop),
    .in_data   ({tag, fifo_rd_data}),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_word),
    .out_ready (out_ready)
  );
  always_comb begin
    state_d = state;
    done    = 1'b0;
    case (state)
      IDLE:    state_d = frame_start ? ACTIVE : IDLE;
      ACTIVE:  state_d = (pop & x_last & y_last) ? DRAIN : ACTIVE;
      DRAIN: begin
        done    = ~out_valid & in_ready;
        state_d = done ? IDLE : DRAIN;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      done    = 1'b0;
    end
  end
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) begin
      state <= IDLE;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      state <= state_d;
      if (abort | ((state == IDLE) & frame_start)) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (pop) begin
        x_cnt <= x_last ? '0 : x_cnt + 1'b1;
        if (x_last) y_cnt <= y_last ? '0 : y_cnt + 1'b1;
      end
    end
`ifdef FIFO_FRAME_READER_STALL_CNT_EN
  always_ff @(posedge rd_clk or posedge rd_rst)
    if (rd_rst) stall_cnt <= '0;
    else if ((state == IDLE) & (state_d == ACTIVE)) stall_cnt <= '0;
    else if (fifo_rd_en & ~fifo_rd_vld & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: scoreboard bench with a FWFT FIFO model feeding the reader (H=4, V=2).
module tb_fifo_frame_reader;
  localparam int H = 4;
  localparam int V = 2;
  typedef struct packed {
    logic [15:0] d;
    logic        s;
    logic        l;
    logic        e;
  } exp_t;
  logic        rd_clk = 1'b0, rd_rst = 1'b1, frame_start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [15:0] fifo_rd_data, out_data;
  logic        fifo_rd_vld, fifo_rd_en, out_valid, out_sof, out_eol, out_eof, busy, done;
`ifdef FIFO_FRAME_READER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int          errors = 0, checks = 0;
  logic [15:0] mem [0:63];
  int          wr_ptr = 0, rd_ptr = 0, pops = 0, starve_at = -1, starve_left = 0;
  int          occ = 0, cyc = 0, acc = 0, first_acc = -1, last_acc = -1;
  exp_t        sb[$];
  logic        hold_v = 1'b0;
  exp_t        hold_w;
  always #5 rd_clk = ~rd_clk;
  fifo_frame_reader #(.DATA_W(16), .H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(12)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .frame_start  (frame_start),
    .abort        (abort),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_vld  (fifo_rd_vld),
    .fifo_rd_en   (fifo_rd_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sof      (out_sof),
    .out_eol      (out_eol),
    .out_eof      (out_eof),
    .busy         (busy),
    .done         (done)
`ifdef FIFO_FRAME_READER_STALL_CNT_EN
    ,.stall_cnt   (stall_cnt)
`endif
  );
  // FWFT FIFO model; starve_left forces rd_vld low for a fixed window
  assign fifo_rd_vld  = (wr_ptr != rd_ptr) && (starve_left == 0);
  assign fifo_rd_data = mem[rd_ptr[5:0]];
  always @(posedge rd_clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en && fifo_rd_vld) begin
      rd_ptr <= rd_ptr + 1;
      pops   <= pops + 1;
      if (pops + 1 == starve_at) starve_left <= 5;
    end else if (starve_left > 0) starve_left <= starve_left - 1;
  end
  always @(posedge rd_clk or posedge rd_rst)
    if (rd_rst || abort) occ <= 0;
    else occ <= occ + int'(fifo_rd_en && fifo_rd_vld) - int'(out_valid && out_ready);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  always @(negedge rd_clk) begin
    if (rd_rst) hold_v = 1'b0;
    else begin
      if (hold_v && out_valid) chk("hold_stable", {out_data, out_sof, out_eol, out_eof}, hold_w);
      hold_v = out_valid && !out_ready && !abort;
      hold_w = {out_data, out_sof, out_eol, out_eof};
      if (out_valid && out_ready) begin
        acc++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        if (sb.size() == 0) chk("unexpected_pixel", {out_data, out_sof, out_eol, out_eof}, 32'hffff_ffff);
        else chk("pixel", {out_data, out_sof, out_eol, out_eof}, sb.pop_front());
      end
      if (fifo_rd_en) chk("rd_en_with_skid_full", occ >= 2 ? 1 : 0, 0);
    end
  end
  task automatic put(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[5:0]] = base + 16'(i);
      wr_ptr++;
    end
  endtask
  task automatic expect_px(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++)
      sb.push_back('{d: base + 16'(i), s: i == 0, l: (i % H) == H - 1, e: i == H * V - 1});
  endtask
  task automatic pulse_start();
    @(posedge rd_clk) #1 frame_start = 1'b1;
    @(posedge rd_clk) #1 frame_start = 1'b0;
  endtask
  task automatic run_frame(input string name, input bit toggle, input int exp_done);
    int dn = 0;
    pulse_start();
    for (int t = 0; t < 40; t++) begin
      @(posedge rd_clk) #1;
      if (toggle) out_ready = ~out_ready;
      @(negedge rd_clk);
      if (done) dn++;
    end
    out_ready = 1'b1;
    chk({name, "_done_pulses"}, dn, exp_done);
    chk({name, "_busy_after"}, busy, 0);
    chk({name, "_sb_empty"}, sb.size(), 0);
  endtask
  initial begin
    int t;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_out_data", out_data, 0);
    repeat (3) @(posedge rd_clk);
    #1 rd_rst = 1'b0;
    // frame of 8 at full rate
    put(16'h0001, 8);
    expect_px(16'h0001, 8);
    first_acc = -1;
    acc = 0;
    run_frame("basic", 1'b0, 1);
    chk("basic_accepts", acc, 8);
    chk("basic_back_to_back", last_acc - first_acc, 7);
    // backpressure toggling
    put(16'h0011, 8);
    expect_px(16'h0011, 8);
    acc = 0;
    run_frame("toggle", 1'b1, 1);
    chk("toggle_accepts", acc, 8);
    // FIFO holds more than one frame
    put(16'h0021, 12);
    expect_px(16'h0021, 8);
    run_frame("extra", 1'b0, 1);
    chk("extra_left", wr_ptr - rd_ptr, 4);
    chk("extra_head", fifo_rd_data, 16'h0029);
    chk("extra_idle_rd_en", fifo_rd_en, 0);
    // starvation at x=2 of the first line
    put(16'h002d, 4);
    expect_px(16'h0029, 8);
    starve_at = pops + 2;
    run_frame("stall", 1'b0, 1);
`ifdef FIFO_FRAME_READER_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 5);
`endif
    // abort with three pixels out and one word in skid
    put(16'h0031, 8);
    expect_px(16'h0031, 3);
    acc = 0;
    pulse_start();
    t = 0;
    while (acc < 3 && t < 40) begin
      @(posedge rd_clk);
      t++;
    end
    chk("abort_reach_3", acc >= 3 ? 1 : 0, 1);
    #1 out_ready = 1'b0;
    @(posedge rd_clk) #1;
    @(negedge rd_clk);
    chk("skid_full_rd_en", fifo_rd_en, 0);
    chk("skid_full_valid", out_valid, 1);
    @(posedge rd_clk) #1 abort = 1'b1;
    @(negedge rd_clk);
    chk("abort_cycle_rd_en", fifo_rd_en, 0);
    chk("abort_cycle_done", done, 0);
    @(posedge rd_clk) #1 abort = 1'b0;
    @(negedge rd_clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_accepts", acc, 3);
    out_ready = 1'b1;
    put(16'h0039, 5);
    expect_px(16'h0036, 8);
    run_frame("restart", 1'b0, 1);
    // asynchronous reset mid-frame
    put(16'h0041, 8);
    out_ready = 1'b0;
    pulse_start();
    repeat (4) @(posedge rd_clk);
    #3 rd_rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", fifo_rd_en, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_tags", {out_sof, out_eol, out_eof}, 0);
`ifdef FIFO_FRAME_READER_STALL_CNT_EN
    chk("arst_stall_cnt", stall_cnt, 0);
`endif
    @(posedge rd_clk) #1 rd_rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge rd_clk);
    chk("post_rst_idle", {out_valid, busy, fifo_rd_en}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
